// File: rtl/br_resolve_bht.sv
// ============================================================================
// Module   : br_resolve_bht
// Purpose  : EX-stage branch resolution with a direct-mapped saturating BHT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_resolve_bht #(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int PC_W      = 64,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic [2:0]        BranchOp,
    input  logic [4:0]        ConBr_type,
    input  logic              Zero,
    input  logic              Negative,
    input  logic              Overflow,
    input  logic              Co,
    output logic [1:0]        PCSrc,
    output logic              ex_taken,
    output logic              mispredict,
    output logic              ex_fallthru,
    output logic              flush_q,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] mis_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Branch operation encodings shared with the decoder
    localparam logic [2:0] c_OP_NONE   = 3'd0;
    localparam logic [2:0] c_OP_BRANCH = 3'd1;
    localparam logic [2:0] c_OP_ZERO   = 3'd2;
    localparam logic [2:0] c_OP_NZERO  = 3'd3;
    localparam logic [2:0] c_OP_COND   = 3'd4;
    localparam logic [2:0] c_OP_ALU    = 3'd5;
    localparam logic [2:0] c_OP_NOINC  = 3'd6;

    // ARM-style condition codes; unlisted codes resolve not-taken
    localparam logic [4:0] c_CC_EQ = 5'd0;
    localparam logic [4:0] c_CC_NE = 5'd1;
    localparam logic [4:0] c_CC_CS = 5'd2;
    localparam logic [4:0] c_CC_CC = 5'd3;
    localparam logic [4:0] c_CC_HI = 5'd8;
    localparam logic [4:0] c_CC_LS = 5'd9;
    localparam logic [4:0] c_CC_GE = 5'd10;
    localparam logic [4:0] c_CC_LT = 5'd11;
    localparam logic [4:0] c_CC_GT = 5'd12;
    localparam logic [4:0] c_CC_LE = 5'd13;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0]  r_bht [BHT_DEPTH];
    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_is_cond;
    logic              w_cond_taken;
    logic              w_train;
    logic              w_unused_bits;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign if_pred_taken = r_bht[w_if_idx][CNT_W-1];
    assign w_unused_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                             ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign w_is_cond = (BranchOp == c_OP_ZERO) || (BranchOp == c_OP_NZERO) ||
                       (BranchOp == c_OP_COND);

    always_comb begin
        w_cond_taken = 1'b0;
        case (ConBr_type)
            c_CC_EQ: w_cond_taken = Zero;
            c_CC_NE: w_cond_taken = ~Zero;
            c_CC_LT: w_cond_taken = Negative ^ Overflow;
            c_CC_LE: w_cond_taken = Zero | (Negative ^ Overflow);
            c_CC_GT: w_cond_taken = ~Zero & ~(Negative ^ Overflow);
            c_CC_GE: w_cond_taken = ~(Negative ^ Overflow);
            c_CC_CC: w_cond_taken = ~Co;
            c_CC_LS: w_cond_taken = ~Co | Zero;
            c_CC_HI: w_cond_taken = Co & ~Zero;
            c_CC_CS: w_cond_taken = Co;
            default: w_cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        ex_taken = 1'b0;
        PCSrc    = 2'b00;
        if (ex_valid) begin
            case (BranchOp)
                c_OP_BRANCH: begin ex_taken = 1'b1;         PCSrc = 2'b01; end
                c_OP_ALU:    begin ex_taken = 1'b1;         PCSrc = 2'b10; end
                c_OP_NOINC:  begin ex_taken = 1'b1;         PCSrc = 2'b11; end
                c_OP_ZERO:   ex_taken = Zero;
                c_OP_NZERO:  ex_taken = ~Zero;
                c_OP_COND:   ex_taken = w_cond_taken;
                c_OP_NONE:   ex_taken = 1'b0;
                default:     ex_taken = 1'b0;
            endcase
            if (w_is_cond && ex_taken) begin
                PCSrc = 2'b01;
            end
        end
    end

    assign w_train     = ex_valid & w_is_cond;
    assign mispredict  = w_train & (ex_taken != ex_pred_taken);
    assign ex_fallthru = mispredict & ~ex_taken;

    // No read bypass: a lookup in the training cycle sees the pre-update value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= c_WEAK_NT;
            end
        end else if (w_train) begin
            if (ex_taken && (r_bht[w_ex_idx] != c_CNT_MAX)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + CNT_W'(1);
            end else if (!ex_taken && (r_bht[w_ex_idx] != '0)) begin
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_q <= 1'b0;
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            flush_q <= mispredict;
            if (w_train && (br_cnt != '1)) begin
                br_cnt <= br_cnt + STAT_W'(1);
            end
            if (mispredict && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + STAT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_br_resolve_bht.sv
// ============================================================================
// Module   : tb_br_resolve_bht
// Purpose  : Directed + random checking of br_resolve_bht against a model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_br_resolve_bht;

    localparam int DEPTH = 64;
    localparam int CW    = 2;
    localparam int PCW   = 64;
    localparam int SW    = 4;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [2:0] OP_NONE = 3'd0, OP_BRANCH = 3'd1, OP_ZERO = 3'd2,
                           OP_NZERO = 3'd3, OP_COND = 3'd4, OP_ALU = 3'd5,
                           OP_NOINC = 3'd6;
    localparam logic [4:0] CC_EQ = 5'd0, CC_NE = 5'd1, CC_CS = 5'd2, CC_CC = 5'd3,
                           CC_HI = 5'd8, CC_LS = 5'd9, CC_GE = 5'd10,
                           CC_LT = 5'd11, CC_GT = 5'd12, CC_LE = 5'd13;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [PCW-1:0] if_pc;
    logic           if_pred_taken;
    logic           ex_valid;
    logic [PCW-1:0] ex_pc;
    logic           ex_pred_taken;
    logic [2:0]     BranchOp;
    logic [4:0]     ConBr_type;
    logic           Zero, Negative, Overflow, Co;
    logic [1:0]     PCSrc;
    logic           ex_taken, mispredict, ex_fallthru, flush_q;
    logic [SW-1:0]  br_cnt, mis_cnt;

    always #5 clk = ~clk;

    br_resolve_bht #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .PC_W(PCW), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .BranchOp(BranchOp), .ConBr_type(ConBr_type), .Zero(Zero),
        .Negative(Negative), .Overflow(Overflow), .Co(Co), .PCSrc(PCSrc),
        .ex_taken(ex_taken), .mispredict(mispredict), .ex_fallthru(ex_fallthru),
        .flush_q(flush_q), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_bht [DEPTH];
    int m_br, m_mis, m_flush;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pc_idx(input logic [PCW-1:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit m_is_cond();
        return BranchOp == OP_ZERO || BranchOp == OP_NZERO || BranchOp == OP_COND;
    endfunction

    function automatic bit m_taken();
        bit lt;
        lt = (Negative != Overflow);
        if (!ex_valid) return 1'b0;
        case (BranchOp)
            OP_BRANCH, OP_ALU, OP_NOINC: return 1'b1;
            OP_ZERO:  return Zero;
            OP_NZERO: return !Zero;
            OP_COND: begin
                case (ConBr_type)
                    CC_EQ: return Zero;
                    CC_NE: return !Zero;
                    CC_LT: return lt;
                    CC_LE: return Zero || lt;
                    CC_GT: return !Zero && !lt;
                    CC_GE: return !lt;
                    CC_CC: return !Co;
                    CC_LS: return !Co || Zero;
                    CC_HI: return Co && !Zero;
                    CC_CS: return Co;
                    default: return 1'b0;
                endcase
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_pcsrc();
        if (!ex_valid) return 2'b00;
        if (BranchOp == OP_BRANCH) return 2'b01;
        if (BranchOp == OP_ALU)    return 2'b10;
        if (BranchOp == OP_NOINC)  return 2'b11;
        if (m_is_cond() && m_taken()) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: check combinational and state outputs, then advance the model
    task automatic step();
        bit t, mis, trn;
        int k;
        #1;
        t   = m_taken();
        trn = ex_valid && m_is_cond();
        mis = trn && (t != ex_pred_taken);
        chk("if_pred", if_pred_taken, 64'(m_bht[pc_idx(if_pc)] >= (1 << (CW - 1))));
        chk("pcsrc",   PCSrc, 64'(m_pcsrc()));
        chk("taken",   ex_taken, 64'(t));
        chk("mispred", mispredict, 64'(mis));
        chk("fallthru", ex_fallthru, 64'(mis && !t));
        chk("flush_q", flush_q, 64'(m_flush));
        chk("br_cnt",  br_cnt, 64'(m_br));
        chk("mis_cnt", mis_cnt, 64'(m_mis));
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_bht[i]) m_bht[i] = (1 << (CW - 1)) - 1;
            m_br = 0; m_mis = 0; m_flush = 0;
        end else begin
            if (trn) begin
                k = pc_idx(ex_pc);
                if (t) m_bht[k] = (m_bht[k] < CMAX) ? m_bht[k] + 1 : CMAX;
                else   m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
                m_br = (m_br < SMAX) ? m_br + 1 : SMAX;
            end
            if (mis) m_mis = (m_mis < SMAX) ? m_mis + 1 : SMAX;
            m_flush = mis;
        end
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; BranchOp = OP_NONE; ConBr_type = CC_EQ; ex_pred_taken = 1'b0;
        Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Co = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        foreach (m_bht[i]) m_bht[i] = 0;
        m_br = 0; m_mis = 0; m_flush = 0;
        rst_n = 1'b0; if_pc = '0; ex_pc = '0;
        idle();
        @(posedge clk); #1;
        // Reset edge while a mispredict is presented: it must not register
        ex_valid = 1'b1; BranchOp = OP_ZERO; Zero = 1'b1; ex_pred_taken = 1'b0; ex_pc = 64'h100;
        step();
        chk("rst_flush", flush_q, 64'd0);
        chk("rst_br", br_cnt, 64'd0);
        chk("rst_mis", mis_cnt, 64'd0);
        rst_n = 1'b1; idle(); if_pc = 64'h100;
        step();
        chk("rst_lookup", if_pred_taken, 64'd0);

        // B.GT taken against a not-taken prediction
        ex_valid = 1'b1; BranchOp = OP_COND; ConBr_type = CC_GT;
        Zero = 1'b0; Negative = 1'b1; Overflow = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 64'h80; if_pc = 64'h80;
        #1;
        chk("bgt_pcsrc", PCSrc, 64'd1);
        chk("bgt_mis", mispredict, 64'd1);
        chk("bgt_fall", ex_fallthru, 64'd0);
        step();
        idle();
        #1;
        chk("bgt_flush", flush_q, 64'd1);
        chk("bgt_miscnt", mis_cnt, 64'd1);
        chk("bgt_entry", if_pred_taken, 64'd1);
        step();

        // CBZ at 0x40: three not-taken then four taken
        do_reset();
        if_pc = 64'h40; ex_pc = 64'h40;
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; BranchOp = OP_ZERO; Zero = 1'b0; ex_pred_taken = 1'b0;
            step();
        end
        chk("cbz_nt_sat", 64'(m_bht[16]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; BranchOp = OP_ZERO; Zero = 1'b1; ex_pred_taken = if_pred_taken;
            step();
            ex_valid = 1'b0; #1;
            chk("cbz_t_pred", if_pred_taken, 64'(i >= 1));
        end

        // Unconditional ALU target: no training, no counters
        do_reset();
        ex_valid = 1'b1; BranchOp = OP_ALU; ex_pred_taken = 1'b0; ex_pc = 64'h40; if_pc = 64'h40;
        step();
        #1;
        chk("alu_br", br_cnt, 64'd0);
        chk("alu_mis", mis_cnt, 64'd0);
        ex_valid = 1'b0; BranchOp = OP_BRANCH;
        #1;
        chk("inv_pcsrc", PCSrc, 64'd0);
        step();

        // Index 5: same-cycle lookup/train returns the old value
        do_reset();
        if_pc = 64'h14; ex_pc = 64'h14;
        ex_valid = 1'b1; BranchOp = OP_ZERO; Zero = 1'b1; ex_pred_taken = 1'b0;
        #1;
        chk("idx5_old", if_pred_taken, 64'd0);
        step();
        idle(); #1;
        chk("idx5_new", if_pred_taken, 64'd1);
        // Training on a reset edge is discarded
        do_reset();
        ex_valid = 1'b1; BranchOp = OP_ZERO; Zero = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1; idle(); #1;
        chk("rst_train", if_pred_taken, 64'd0);
        step();

        // 16 mispredicts saturate the 4-bit counters
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ex_valid = 1'b1; BranchOp = OP_COND; ConBr_type = CC_EQ; Zero = 1'b1;
            ex_pred_taken = 1'b0; ex_pc = 64'(i * 4 + 64'h1000);
            step();
        end
        chk("mis_sat", mis_cnt, 64'd15);
        chk("br_sat", br_cnt, 64'd15);

        // Unknown condition code
        ConBr_type = 5'h1F; Zero = 1'b1; Co = 1'b1;
        #1;
        chk("cc1f_taken", ex_taken, 64'd0);
        chk("cc1f_pcsrc", PCSrc, 64'd0);
        step();

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            ex_valid      = ($urandom_range(0, 7) != 0);
            BranchOp      = 3'($urandom_range(0, 7));
            ConBr_type    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
            Zero          = 1'($urandom); Negative = 1'($urandom);
            Overflow      = 1'($urandom); Co = 1'($urandom);
            ex_pc         = {32'($urandom), 24'($urandom), 3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
            if_pc         = ($urandom_range(0, 2) == 0) ? ex_pc : {32'($urandom), 32'($urandom)};
            ex_pred_taken = ($urandom_range(0, 1) == 0) ? 1'($urandom)
                                                        : 1'(m_bht[pc_idx(ex_pc)] >= (1 << (CW - 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/br_resolve_bht.md
# br_resolve_bht

Parametrised branch resolution and prediction unit for the LEGv8 pipeline. It combines EX-stage branch resolution with a direct-mapped branch history table (BHT) of saturating counters that is read in IF and trained in EX. Resolution covers unconditional, CBZ/CBNZ, BR, no-increment and B.cond (signed and unsigned) branches from the ALU flags. It produces PCSrc, a misprediction/redirect indication, a one-cycle registered flush pulse and saturating statistics counters.

## Interface
- BHT_DEPTH, 64, number of BHT entries; power of two, at least 2; IDX_W = log2(BHT_DEPTH)
- CNT_W, 2, width of each saturating counter; at least 1
- PC_W, 64, program counter width
- STAT_W, 32, width of statistics counters
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- if_pc  in  PC_W  fetch PC used for lookup
- if_pred_taken  out  1  prediction for if_pc; combinational
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction
- BranchOp  in  3  branch operation code (BCOND_OP_* from common.vh)
- ConBr_type  in  5  B.cond condition code (BCOND_* from common.vh)
- Zero, Negative, Overflow, Co  in  1 each  ALU flags for the EX instruction
- PCSrc  out  2  PC source select: 00 sequential, 01 branch target, 10 ALU/register target, 11 no increment
- ex_taken  out  1  resolved direction of the EX branch
- mispredict  out  1  combinational redirect request
- ex_fallthru  out  1  redirect target is ex_pc+4 (mispredict and not taken)
- flush_q  out  1  registered mispredict, one cycle later
- br_cnt  out  STAT_W  count of resolved conditional branches
- mis_cnt  out  STAT_W  count of mispredictions

## Operation
- Lookup: idx = if_pc[IDX_W+1:2]. if_pred_taken = MSB of bht[idx]. The read is combinational and sees the array state before the current edge.
- is_cond = BranchOp is BCOND_OP_ZERO, BCOND_OP_NZERO or BCOND_OP_COND.
- Direction (ex_taken):
  - BRANCH, ALU, NOINC: taken = 1.
  - ZERO: taken = Zero. NZERO: taken = ~Zero.
  - COND:
    - EQ: Z. NE: ~Z.
    - LT: N!=V. LE: Z | (N!=V). GT: ~Z & (N==V). GE: N==V.
    - CC: ~Co. LS: ~Co | Z. HI: Co & ~Z. CS: Co.
    - Any other code: 0.
  - Other BranchOp: taken = 0.
- PCSrc is fully combinational with a default of 00; no latches.
  - BRANCH gives 01, ALU gives 10, NOINC gives 11.
  - A conditional branch gives 01 if taken, otherwise 00.
  - ex_valid=0 forces PCSrc=00 and ex_taken=0.
- mispredict = ex_valid & is_cond & (ex_taken != ex_pred_taken). Unconditional ops never assert mispredict.
- ex_fallthru = mispredict & ~ex_taken. The PC mux then selects ex_pc+4 regardless of PCSrc.
- Training: on an edge with ex_valid & is_cond, the entry at ex_pc[IDX_W+1:2] updates.
  - Taken: increment, saturating at 2^CNT_W-1.
  - Not taken: decrement, saturating at 0.
  - Other entries are unchanged.
- Statistics, each saturating at all-ones (no wrap):
  - br_cnt increments on every training edge.
  - mis_cnt increments on every edge with mispredict=1.
- Reset (rst_n=0 at an edge):
  - Every BHT entry is set to 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2).
  - flush_q=0, br_cnt=0, mis_cnt=0.
  - Reset overrides a same-edge training write and a same-edge counter increment.

## Timing
- Lookup, resolution, PCSrc, mispredict and ex_fallthru have zero latency (combinational).
- A BHT update is visible to lookups from the cycle after the training edge.
  - Same-cycle read/write to the same index returns the old value; there is no bypass.
- flush_q = mispredict delayed by one cycle. Back-to-back mispredicts give flush_q high on consecutive cycles.
- Counters reflect an event one cycle after it.
- Reset mid-operation: outputs driven by state (if_pred_taken, flush_q, counters) show reset values from the cycle after the reset edge.
  - Combinational outputs keep following their inputs.
- Aliasing: distinct PCs with equal index bits share one entry. This is intended.

## Test plan
- Reset, then lookup if_pc=0x100 -> if_pred_taken=0. Trigger one mispredict -> flush_q=0 before reset, and br_cnt=0, mis_cnt=0 after reset.
- B.GT with Z=0, N=V=1 and ex_pred_taken=0 -> PCSrc=01, ex_taken=1, mispredict=1, ex_fallthru=0. Next cycle: flush_q=1, mis_cnt=1, entry=10.
- CBZ at ex_pc=0x40 not taken, repeated 3 times from reset -> entry goes 01→00→00 (saturates).
  - Then 4 taken -> entry 01→10→11→11, and if_pred_taken for 0x40 becomes 1 after the second taken.
- BranchOp=BCOND_OP_ALU with ex_pred_taken=0 -> PCSrc=10, mispredict=0, no BHT or counter change. ex_valid=0 with BRANCH -> PCSrc=00.
- Same-cycle lookup and train on index 5 -> if_pred_taken shows the old value, new value the next cycle.
  - Assert rst_n=0 on a training edge -> entry stays at 01.
- STAT_W=4: drive 16 mispredicts -> mis_cnt saturates at 15. Unknown ConBr_type=5'h1F -> ex_taken=0, PCSrc=00.
